// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FIFO slice.
//   cap_state_t  - capture FSM states (IDLE, ACK, HOLD)
//   DEPTH_DEF    - default FIFO depth in bytes
//   THRESH_DEF   - default interrupt fill threshold
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } cap_state_t;

  localparam int DEPTH_DEF  = 16;
  localparam int THRESH_DEF = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with an up/down occupancy counter.
//   clk_5m  in   clock, rising edge
//   rst     in   synchronous active-high reset (pointers/count only)
//   wr_en   in   push request; accepted when not full or when a pop
//                is accepted in the same cycle
//   wr_data in   byte to push
//   rd_en   in   pop request; ignored while empty
//   rd_data out  head entry, valid while empty=0
//   full    out  count == DEPTH
//   empty   out  count == 0
//   count   out  number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk_5m,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // A pop frees the slot the push needs, so full only blocks a lone push.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage is data path: never reset, only written on an accepted push.
  always_ff @(posedge clk_5m) begin
    if (wr_ok && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count is tracked
  // separately so full and empty are distinguishable.
  always_ff @(posedge clk_5m) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive-side byte FIFO with handshake capture and interrupt.
//   clk_5m     in   clock, rising edge
//   rst        in   synchronous active-high reset
//   rx_rdy     in   byte-ready flag from the receiver
//   rx_data    in   received byte, valid while rx_rdy=1
//   rx_rdy_clr out  registered one-cycle acknowledge per captured byte
//   rd_en      in   consumer pop request
//   rd_data    out  head byte (show-ahead), valid while rd_valid=1
//   rd_valid   out  FIFO not empty
//   count      out  stored bytes, 0..DEPTH
//   full       out  count == DEPTH
//   ovf        out  sticky overflow (byte dropped while full)
//   ovf_clr    in   clears ovf; a simultaneous new overflow wins
//   irq        out  count >= THRESH or ovf
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic                   clk_5m,
  input  logic                   rst,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   rx_rdy_clr,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic                   irq
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  cap_state_t state;
  logic       push;
  logic       pop;
  logic       empty;
  logic       ovf_set;

  // Capture only from IDLE; ACK and HOLD form a blind window that covers
  // the receiver's delay in dropping rx_rdy after the acknowledge.
  assign push    = (state == IDLE) && rx_rdy;
  assign pop     = rd_en && !empty;
  assign ovf_set = push && full && !pop;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_5m  (clk_5m),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (rx_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign rd_valid = !empty;
  assign irq      = (count >= THRESH_C) || ovf;

  always_ff @(posedge clk_5m) begin
    if (rst) begin
      state      <= IDLE;
      rx_rdy_clr <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rx_rdy_clr <= 1'b0;
          if (rx_rdy) begin
            rx_rdy_clr <= 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          rx_rdy_clr <= 1'b0;
          state      <= HOLD;
        end
        HOLD: begin
          rx_rdy_clr <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          rx_rdy_clr <= 1'b0;
          state      <= IDLE;
        end
      endcase

      // Set has priority over clear so an overflow is never lost.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk_5m = 1'b0;
  logic          rst;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rx_rdy_clr;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          ovf;
  logic          ovf_clr;
  logic          irq;

  always #5 clk_5m = ~clk_5m;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .THRESH (THRESH)
  ) dut (
    .clk_5m     (clk_5m),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_rdy_clr (rx_rdy_clr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count),
    .full       (full),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .irq        (irq)
  );

  int n_checks = 0;
  int n_errors = 0;
  int clr_pulses = 0;

  // Reference model: byte queue, sticky overflow, and a capture lockout
  // of two edges after every accepted capture.
  logic [7:0] q[$];
  int         blind = 0;
  bit         m_ovf = 1'b0;
  bit         m_clr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit cap;
    bit pop;
    if (rst) begin
      q.delete();
      blind = 0;
      m_ovf = 1'b0;
      m_clr = 1'b0;
    end else begin
      cap = rx_rdy && (blind == 0);
      pop = rd_en && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) q.push_back(rx_data);
        else                  m_ovf = 1'b1;
      end
      if (!(cap && q.size() == DEPTH && !pop && m_ovf) && ovf_clr) begin
        // clear only when this edge did not just record an overflow
      end
      m_clr = cap;
      blind = cap ? 2 : ((blind > 0) ? blind - 1 : 0);
    end
  endtask

  // One clock: update model at the edge, compare everything 1 time unit later.
  task automatic cycle();
    bit was_ovf;
    bit new_ovf;
    int pre_size;
    bit cap;
    bit pop;
    @(posedge clk_5m);
    pre_size = q.size();
    was_ovf  = m_ovf;
    cap      = !rst && rx_rdy && (blind == 0);
    pop      = !rst && rd_en && (pre_size > 0);
    new_ovf  = cap && !pop && (pre_size == DEPTH);
    model_edge();
    if (!rst && !new_ovf && ovf_clr) m_ovf = 1'b0;
    if (!rst && !new_ovf && !ovf_clr) m_ovf = was_ovf;
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("irq", 32'(irq), 32'((q.size() >= THRESH) || m_ovf));
    chk("rx_rdy_clr", 32'(rx_rdy_clr), 32'(m_clr));
    if (q.size() > 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
    if (rx_rdy_clr) clr_pulses++;
  endtask

  // Receiver model: raise rx_rdy, drop it the cycle after the acknowledge.
  task automatic send(input logic [7:0] b);
    int guard;
    guard   = 0;
    rx_data = b;
    rx_rdy  = 1'b1;
    do begin
      cycle();
      guard++;
    end while (!rx_rdy_clr && guard < 8);
    if (!rx_rdy_clr) chk("ack_timeout", 32'(rx_rdy_clr), 32'(1));
    rx_rdy = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;

    // Reset state
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_valid", 32'(rd_valid), 32'(0));
    chk("rst_irq", 32'(irq), 32'(0));
    chk("rst_clr", 32'(rx_rdy_clr), 32'(0));

    // Single byte
    clr_pulses = 0;
    send(8'hA5);
    cycle();
    chk("single_pulses", 32'(clr_pulses), 32'(1));
    chk("single_data", 32'(rd_data), 32'h0A5);
    chk("single_valid", 32'(rd_valid), 32'(1));
    chk("single_count", 32'(count), 32'(1));

    // Stuck rdy: rx_rdy held three cycles for one byte
    do_reset();
    clr_pulses = 0;
    rx_data = 8'hB7;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    rx_rdy = 1'b0;
    cycle();
    cycle();
    chk("stuck_pulses", 32'(clr_pulses), 32'(1));
    chk("stuck_count", 32'(count), 32'(1));
    chk("stuck_data", 32'(rd_data), 32'h0B7);

    // Fill and overflow
    do_reset();
    clr_pulses = 0;
    for (int i = 0; i <= 16; i++) send(8'(i));
    chk("fill_pulses", 32'(clr_pulses), 32'(17));
    chk("fill_full", 32'(full), 32'(1));
    chk("fill_count", 32'(count), 32'(16));
    chk("fill_ovf", 32'(ovf), 32'(1));
    chk("fill_irq", 32'(irq), 32'(1));
    for (int i = 0; i < 16; i++) pop_chk("fill_order", 8'(i));
    chk("drain_valid", 32'(rd_valid), 32'(0));
    chk("drain_irq_ovf", 32'(irq), 32'(1));
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'(0));
    chk("irq_cleared", 32'(irq), 32'(0));

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i));
    rx_data = 8'h5A;
    rx_rdy  = 1'b1;
    rd_en   = 1'b1;
    cycle();
    rd_en  = 1'b0;
    rx_rdy = 1'b0;
    chk("fp_ack", 32'(rx_rdy_clr), 32'(1));
    cycle();
    cycle();
    chk("fp_count", 32'(count), 32'(16));
    chk("fp_ovf", 32'(ovf), 32'(0));
    chk("fp_head", 32'(rd_data), 32'h01);
    for (int i = 1; i < 16; i++) pop_chk("fp_order", 8'(i));
    pop_chk("fp_last", 8'h5A);
    chk("fp_empty", 32'(rd_valid), 32'(0));

    // Wrap with 1-5 outstanding, then threshold edges
    do_reset();
    begin
      int pushed;
      int popped;
      pushed = 0;
      popped = 0;
      while (popped < 20) begin
        if (pushed < 20 && (pushed - popped) < int'($urandom_range(1, 5))) begin
          send(8'(8'h40 + pushed));
          pushed++;
        end else begin
          pop_chk("wrap_order", 8'(8'h40 + popped));
          popped++;
        end
        chk("wrap_irq", 32'(irq), 32'(0));
      end
    end
    for (int i = 0; i < 7; i++) send(8'(i));
    chk("thr7_irq", 32'(irq), 32'(0));
    send(8'h07);
    chk("thr8_count", 32'(count), 32'(8));
    chk("thr8_irq", 32'(irq), 32'(1));
    pop_chk("thr_pop", 8'h00);
    chk("thr7b_irq", 32'(irq), 32'(0));

    // Reset mid-stream during an ACK cycle
    do_reset();
    for (int i = 0; i < 5; i++) send(8'(8'h80 + i));
    rx_data = 8'h99;
    rx_rdy  = 1'b1;
    cycle();
    chk("mid_in_ack", 32'(rx_rdy_clr), 32'(1));
    rx_rdy = 1'b0;
    rst    = 1'b1;
    rd_en  = 1'b1;
    cycle();
    rst   = 1'b0;
    rd_en = 1'b0;
    chk("mid_count", 32'(count), 32'(0));
    chk("mid_valid", 32'(rd_valid), 32'(0));
    chk("mid_clr", 32'(rx_rdy_clr), 32'(0));
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("mid_ovf", 32'(ovf), 32'(0));
    rx_data = 8'h3C;
    rx_rdy  = 1'b1;
    cycle();
    rx_rdy = 1'b0;
    chk("mid_idle_capture", 32'(rx_rdy_clr), 32'(1));
    cycle();
    cycle();
    // Capture and pop coinciding with reset leave nothing behind
    rst    = 1'b1;
    rx_rdy = 1'b1;
    rd_en  = 1'b1;
    cycle();
    rst    = 1'b0;
    rx_rdy = 1'b0;
    rd_en  = 1'b0;
    chk("rst_cap_count", 32'(count), 32'(0));
    chk("rst_cap_clr", 32'(rx_rdy_clr), 32'(0));

    // Randomized traffic; fill-biased first half, drain-biased second half
    for (int k = 0; k < 3000; k++) begin
      if (rx_rdy && rx_rdy_clr) begin
        rx_rdy = ($urandom_range(0, 3) == 0);
      end else if (!rx_rdy && $urandom_range(0, 1) == 1) begin
        rx_rdy  = 1'b1;
        rx_data = 8'($urandom);
      end
      rd_en   = (k < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
      ovf_clr = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst     = 1'b0;
    rx_rdy  = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
